// File: rtl/loader_pkg.sv
// Shared widths, state encoding and stream-format constants
// for the boot-time program loader.
package loader_pkg;
  localparam int INSTR_BUS_WIDTH = 17;
  localparam int BUS_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;
  localparam logic [BUS_WIDTH-1:0] B0_RESERVED_MASK = 8'hFE;
  localparam int COUNT_ZERO_MEANS = 256;

  typedef enum logic [3:0] {
    IDLE, LEN, B0, B1, B2, WRITE, RELEASE, RUN, ERROR
  } state_t;

  // Count byte of 0 encodes a full 256-word image.
  function automatic logic [8:0] count_of(
    input logic [BUS_WIDTH-1:0] n
  );
    return (n == '0) ? 9'(COUNT_ZERO_MEANS)
                     : {1'b0, n};
  endfunction
endpackage

// File: rtl/program_loader_if.sv
// Byte-source handshake plus instruction-memory write port.
// master = source/memory side, slave = loader side.
interface program_loader_if;
  import loader_pkg::*;

  logic                       byte_valid;
  logic [BUS_WIDTH-1:0]       byte_data;
  logic                       byte_ready;
  logic                       imem_we;
  logic [ADDR_WIDTH-1:0]      imem_addr;
  logic [INSTR_BUS_WIDTH-1:0] imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we,
    input  imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we,
    output imem_addr, imem_wdata
  );
endinterface

// File: rtl/byte_packer.sv
// Latches B0[0] and B1, then captures the full 17-bit word
// on the B2 strobe; the word holds until the next B2.
module byte_packer
  import loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 ld,
  input  logic [BUS_WIDTH-1:0]       data,
  output logic [INSTR_BUS_WIDTH-1:0] word
);
  logic                 b16;
  logic [BUS_WIDTH-1:0] b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b16  <= 1'b0;
      b1   <= '0;
      word <= '0;
    end else begin
      if (ld[0]) b16 <= data[0];
      if (ld[1]) b1 <= data;
      if (ld[2]) word <= {b16, b1, data};
    end
  end
endmodule

// File: rtl/program_loader.sv
// Boot sequencer: holds the CPU in reset, streams 3-byte
// words into instruction memory, then releases the CPU.
module program_loader
  import loader_pkg::*;
#(
  parameter int RELEASE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  program_loader_if.slave  bus,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             error
);
  localparam int RW =
    (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [8:0]            wr_cnt;
  logic [8:0]            target;
  logic [RW-1:0]         rel_cnt;
  logic                  acc;
  logic                  b0_bad;
  logic [2:0]            ld;

  assign acc    = bus.byte_valid & bus.byte_ready;
  assign b0_bad = |(bus.byte_data & B0_RESERVED_MASK);
  assign ld     = {acc & (state == B2),
                   acc & (state == B1),
                   acc & (state == B0) & ~b0_bad};

  byte_packer u_packer (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .data (bus.byte_data),
    .word (bus.imem_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cpu_rst        <= 1'b1;
      bus.byte_ready <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      addr_cnt       <= '0;
      wr_cnt         <= '0;
      target         <= '0;
      rel_cnt        <= '0;
    end else begin
      unique case (state)
        IDLE, RUN, ERROR: begin
          if (start) begin
            state          <= LEN;
            busy           <= 1'b1;
            bus.byte_ready <= 1'b1;
            cpu_rst        <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            addr_cnt       <= '0;
            wr_cnt         <= '0;
          end else if (run && state != RUN) begin
            state   <= RELEASE;
            rel_cnt <= '0;
            error   <= 1'b0;
          end
        end
        LEN: if (acc) begin
          target <= count_of(bus.byte_data);
          state  <= B0;
        end
        B0: if (acc) begin
          if (b0_bad) begin
            state          <= ERROR;
            error          <= 1'b1;
            busy           <= 1'b0;
            bus.byte_ready <= 1'b0;
          end else begin
            state <= B1;
          end
        end
        B1: if (acc) state <= B2;
        B2: if (acc) begin
          state          <= WRITE;
          bus.byte_ready <= 1'b0;
          bus.imem_we    <= 1'b1;
          bus.imem_addr  <= addr_cnt;
        end
        WRITE: begin
          bus.imem_we <= 1'b0;
          addr_cnt    <= addr_cnt + 1'b1;
          wr_cnt      <= wr_cnt + 9'd1;
          if (wr_cnt + 9'd1 == target) begin
            state   <= RELEASE;
            rel_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            state          <= B0;
            bus.byte_ready <= 1'b1;
          end
        end
        RELEASE: begin
          if (rel_cnt == RW'(RELEASE_CYCLES - 1)) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
            done    <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: vector table, hand sequences and
// random byte streams checked against a stream-format model.
module tb_program_loader;
  import loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic run = 1'b0;
  logic cpu_rst, busy, done, error;
  int   checks = 0;
  int   errors = 0;

  program_loader_if bus();

  program_loader #(.RELEASE_CYCLES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .run     (run),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write strobe must follow exactly the edge that accepted a B2.
  int          bidx = 0;
  logic        exp_we = 1'b0;
  logic [24:0] got[$];

  always @(posedge clk) begin
    exp_we = 1'b0;
    if (rst && bus.byte_valid && bus.byte_ready) begin
      if (bidx > 0 && (bidx - 1) % 3 == 2) exp_we = 1'b1;
      bidx++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("we_strobe", 32'(bus.imem_we), 32'(exp_we));
      if (bus.imem_we)
        got.push_back({bus.imem_addr, bus.imem_wdata});
    end
  end

  // Reference: the byte stream rules, independent of the FSM.
  logic [7:0]  stream[$];
  logic [24:0] exp_w[$];
  logic        exp_err;
  int          nsend;

  task automatic model();
    int         n;
    logic [7:0] b0;
    exp_w.delete();
    exp_err = 1'b0;
    n = (stream[0] == 8'd0) ? 256 : int'(stream[0]);
    nsend = 1 + 3 * n;
    for (int i = 0; i < n; i++) begin
      b0 = stream[1 + 3 * i];
      if (b0[7:1] != 7'd0) begin
        exp_err = 1'b1;
        nsend = 2 + 3 * i;
        break;
      end
      exp_w.push_back({8'(i), b0[0],
                       stream[2 + 3 * i], stream[3 + 3 * i]});
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
    end
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end
  endtask

  task automatic feed(input int gap);
    for (int i = 0; i < nsend; i++)
      send(stream[i], gap < 0 ? int'($urandom_range(0, 2)) : gap);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_start(input logic with_run);
    @(negedge clk);
    start = 1'b1;
    run   = with_run;
    @(negedge clk);
    start = 1'b0;
    run   = 1'b0;
    bidx  = 0;
    got.delete();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(bus.byte_ready), 32'd1);
    chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_error", 32'(error), 32'd0);
  endtask

  task automatic finish_load();
    logic [24:0] lw;
    if (exp_err) begin
      chk("err_flag", 32'(error), 32'd1);
      chk("err_ready", 32'(bus.byte_ready), 32'd0);
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_cpu_rst", 32'(cpu_rst), 32'd1);
      repeat (3) @(negedge clk);
      chk("err_sticky", 32'(error), 32'd1);
      chk("err_done", 32'(done), 32'd0);
    end else begin
      lw = exp_w[exp_w.size() - 1];
      chk("last_we", 32'(bus.imem_we), 32'd1);
      chk("last_addr", 32'(bus.imem_addr), 32'(lw[24:17]));
      chk("last_data", 32'(bus.imem_wdata), 32'(lw[16:0]));
      @(negedge clk);
      chk("rel1_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rel1_busy", 32'(busy), 32'd0);
      chk("rel1_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("rel2_cpu_rst", 32'(cpu_rst), 32'd1);
      @(negedge clk);
      chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("run_done", 32'(done), 32'd1);
      chk("run_error", 32'(error), 32'd0);
    end
    chk("write_count", 32'(got.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      chk("write", 32'(got[i]), 32'(exp_w[i]));
  endtask

  typedef struct {
    int          nb;
    logic [55:0] b;
    int          gap;
    logic        err;
    int          nw;
    logic [16:0] w0;
    logic [16:0] w1;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    tbl[0] = '{7, 56'h0201A35C001234, 0, 1'b0, 2,
               17'h1A35C, 17'h01234};
    tbl[1] = '{7, 56'h0201A35C001234, 3, 1'b0, 2,
               17'h1A35C, 17'h01234};
    tbl[2] = '{2, 56'h01040000000000, 0, 1'b1, 0,
               17'h0, 17'h0};
    tbl[3] = '{4, 56'h01000007000000, 0, 1'b0, 1,
               17'h00007, 17'h0};
    tbl[4] = '{4, 56'h0101FFFF000000, 1, 1'b0, 1,
               17'h1FFFF, 17'h0};
    tbl[5] = '{5, 56'h0200AABB800000, 2, 1'b1, 1,
               17'h0AABB, 17'h0};

    #1 rst = 1'b0;
    #2;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.imem_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("idle_ready", 32'(bus.byte_ready), 32'd0);
    chk("idle_we", 32'(bus.imem_we), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    for (int v = 0; v < 6; v++) begin
      stream.delete();
      exp_w.delete();
      for (int j = 0; j < tbl[v].nb; j++)
        stream.push_back(8'(tbl[v].b >> (8 * (6 - j))));
      nsend   = tbl[v].nb;
      exp_err = tbl[v].err;
      if (tbl[v].nw > 0) exp_w.push_back({8'd0, tbl[v].w0});
      if (tbl[v].nw > 1) exp_w.push_back({8'd1, tbl[v].w1});
      do_start(1'b0);
      feed(tbl[v].gap);
      finish_load();
    end

    // start and run together: start wins
    stream = '{8'h01, 8'h00, 8'h12, 8'h34};
    model();
    do_start(1'b1);
    feed(0);
    finish_load();

    // full 256-word image with ignored start/run mid-load
    stream.delete();
    stream.push_back(8'h00);
    for (int k = 0; k < 256; k++) begin
      stream.push_back({7'd0, 1'($urandom)});
      stream.push_back(8'($urandom));
      stream.push_back(8'($urandom));
    end
    model();
    do_start(1'b0);
    for (int i = 0; i < nsend; i++) begin
      if (i == 300 || i == 400) begin
        @(negedge clk);
        bus.byte_valid = 1'b0;
        start = (i == 300);
        run   = (i == 400);
        @(negedge clk);
        start = 1'b0;
        run   = 1'b0;
        chk("busy_ignore", 32'(busy), 32'd1);
      end
      send(stream[i], 0);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    finish_load();

    for (int t = 0; t < 10; t++) begin
      int ni;
      ni = int'($urandom_range(1, 6));
      stream.delete();
      stream.push_back(8'(ni));
      for (int k = 0; k < ni; k++) begin
        if ($urandom_range(0, 7) == 0)
          stream.push_back(8'($urandom));
        else
          stream.push_back({7'd0, 1'($urandom)});
        stream.push_back(8'($urandom));
        stream.push_back(8'($urandom));
      end
      model();
      do_start(1'b0);
      feed(-1);
      finish_load();
    end

    // async reset after B1, then run the current image
    do_start(1'b0);
    send(8'h02, 0);
    send(8'h01, 0);
    send(8'hA3, 0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("mid_rst_we", 32'(bus.imem_we), 32'd0);
    @(negedge clk);
    rst  = 1'b1;
    bidx = 0;
    got.delete();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("runonly_rel1", 32'(cpu_rst), 32'd1);
    chk("runonly_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("runonly_rel2", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    chk("runonly_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("runonly_done", 32'(done), 32'd1);
    chk("runonly_writes", 32'(got.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot/load sequencer for the 5-stage pipelined CPU.
- Holds the CPU in reset and accepts a byte stream from a valid/ready source (UART or keyboard bridge).
- Packs every 3 bytes into one 17-bit instruction word, writes each word into instruction memory at consecutive addresses, then releases the CPU to fetch from address 0.
- Sits between the byte source, the instruction memory write port and the CPU's synchronous active-high reset input.

Parameters:
- INSTR_BUS_WIDTH, 17, instruction word width including opcode.
- BUS_WIDTH, 8, byte/data width.
- ADDR_WIDTH, 8, instruction memory address width; must equal the PC width.
- RELEASE_CYCLES, 2, cycles cpu_rst stays high after the final write.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin a new load.
- run  in  1  one-cycle pulse: release CPU without loading (runs current image).
- byte_valid  in  1  source has a byte.
- byte_data  in  BUS_WIDTH  byte payload.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_WIDTH  write address.
- imem_wdata  out  INSTR_BUS_WIDTH  write data.
- cpu_rst  out  1  active-high synchronous reset to CPU.
- busy  out  1  load in progress.
- done  out  1  CPU released after successful load or run.
- error  out  1  format error; sticky until start or run.

Behaviour:
- Reset values (rst=0, applied asynchronously):
  - state=IDLE, cpu_rst=1, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - busy=0, done=0, error=0, internal counters=0.
- All outputs are registered.
- Byte transfer occurs on a rising edge where byte_valid & byte_ready.
- byte_ready=1 only in LEN, B0, B1 and B2. byte_data is ignored otherwise.
- Stream format:
  - Count byte N first; N=0 means 256 instructions.
  - Then per instruction: B0, B1, B2.
  - B0[0] → instr[16]; B0[7:1] must be 0. B1 → instr[15:8]. B2 → instr[7:0].
- States:
  - IDLE: cpu_rst=1. start → LEN (busy=1, addr counter=0). run → RELEASE. If start and run arrive in the same cycle, start wins.
  - LEN: accept N → B0.
  - B0: accept byte. If B0[7:1]≠0 → ERROR. Otherwise latch bit 16 → B1.
  - B1: accept byte, latch → B2.
  - B2: accept byte, latch → WRITE.
  - WRITE: imem_we=1 for exactly one cycle with imem_addr=addr counter and imem_wdata=assembled word. Then addr counter +1.
    - If written count == N (256 when N=0), → RELEASE.
    - Otherwise → B0.
  - RELEASE: cpu_rst=1 for RELEASE_CYCLES cycles, busy=0. Then → RUN.
  - RUN: cpu_rst=0, done=1. start → LEN, which reasserts cpu_rst=1 and clears done the next cycle.
  - ERROR: cpu_rst=1, error=1, byte_ready=0. start → LEN (clears error). run → RELEASE (clears error).
- Timing:
  - imem_we rises the cycle after B2 is accepted.
  - Minimum 4 cycles per instruction.
  - Stalls on byte_valid=0 are unbounded; no timeout.
- start or run while busy (LEN..WRITE) is ignored.
- The address counter is ADDR_WIDTH bits and wraps. With N=0, the final write is at 0xFF and the counter returns to 0.
- Async reset mid-load returns to IDLE immediately, cpu_rst=1. Partially loaded memory contents are not cleaned up.
- imem_wdata holds its last value when imem_we=0.

Decomposition:
- Shared package (loader_pkg) holds:
  - state enum: IDLE, LEN, B0, B1, B2, WRITE, RELEASE, RUN, ERROR.
  - constants B0_RESERVED_MASK=8'hFE and COUNT_ZERO_MEANS=256.
- One natural sub-module: byte_packer. It is a 3-byte shift/latch assembling the 17-bit word, with load strobes per byte index.
- The FSM and counters stay in program_loader.

Test Plan:
- Reset then idle: rst low→high, no stimulus for 10 cycles → cpu_rst=1, byte_ready=0, imem_we=0, done=0.
- Two-instruction load: start, then bytes 02,01,A3,5C,00,12,34 back-to-back:
  - imem_we pulses twice, writing 0x1A35C@0 and 0x01234@1.
  - cpu_rst stays 1 for 2 cycles after the second write, then 0 with done=1.
- Stalled source: same stream with byte_valid deasserted 3 cycles between every byte → identical writes. imem_we is never asserted except the cycle after each B2.
- Format error: start, bytes 01,04 → error=1, byte_ready=0, no imem_we. Then start, 01,00,00,07 → error=0, write 0x00007@0, then RUN.
- N=0 boundary: start, 00, then 768 bytes → 256 writes at addresses 0x00..0xFF in order, then release. A start pulse mid-load is ignored.
- Mid-load reset and run: assert rst after B1 of instr 1 → immediate IDLE, cpu_rst=1. Then run → cpu_rst deasserts 2 cycles later, done=1, no writes.
